// File: rtl/uart_rx_deserializer.sv
// 16x-oversampling UART receiver (8N1 / 8E1 / 8O1) feeding a receive FIFO write port.
// Bits are decided by a 3-sample majority vote around mid-bit; the receiver re-arms at mid-stop-bit.
module uart_rx_deserializer #(
  parameter int CLKS_PER_TICK = 27,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       fifo_full,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam logic [15:0] TICK_MAX    = 16'(CLKS_PER_TICK - 1);
  localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  MID_SAMPLE  = 4'd9;

  state_t      state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] tick_cnt;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_cnt;
  logic        s7, s8;
  logic [7:0]  shreg;
  logic        par_en_l, par_odd_l, par_bad;
  logic        tick, maj;

  assign tick = (tick_cnt == TICK_MAX);
  // Majority of samples 7, 8 and the live sample 9.
  assign maj  = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      shreg       <= '0;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      par_bad     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block deliberately
      // override earlier ones (sticky-flag sets beat err_clr, start detection clears tick_cnt).
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      tick_cnt <= tick ? '0 : tick_cnt + 16'd1;

      if (err_clr) begin
        framing_err <= 1'b0;
        parity_err  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (rx_valid && fifo_full) overrun_err <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state      <= START;
            busy       <= 1'b1;
            tick_cnt   <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            par_bad    <= 1'b0;
            par_en_l   <= parity_en;
            par_odd_l  <= parity_odd;
          end
        end

        WAIT_HIGH: begin
          // Hold off through a break so a stuck-low line cannot spawn frames.
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd7) s7 <= rx_sync;
            if (sample_cnt == 4'd8) s8 <= rx_sync;

            case (state)
              START: begin
                if (sample_cnt == MID_SAMPLE && maj) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else if (sample_cnt == LAST_SAMPLE) begin
                  state <= DATA;
                end
              end

              DATA: begin
                if (sample_cnt == MID_SAMPLE) shreg <= {maj, shreg[7:1]};
                if (sample_cnt == LAST_SAMPLE) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= par_en_l ? PARITY : STOP;
                end
              end

              PARITY: begin
                if (sample_cnt == MID_SAMPLE) par_bad <= (^shreg) ^ maj ^ par_odd_l;
                if (sample_cnt == LAST_SAMPLE) state <= STOP;
              end

              STOP: begin
                if (sample_cnt == MID_SAMPLE) begin
                  if (maj) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (par_bad) begin
                      parity_err <= 1'b1;
                    end else begin
                      rx_data  <= shreg;
                      rx_valid <= 1'b1;
                    end
                  end else begin
                    state       <= WAIT_HIGH;
                    framing_err <= 1'b1;
                    if (par_bad) parity_err <= 1'b1;
                  end
                end
              end

              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLKS_PER_TICK = 4 (64 clk per bit).
// Frames are driven on the falling clock edge; outputs are sampled on the falling edge.
module tb_uart_rx_deserializer;

  localparam int CPT = 4;
  localparam int BIT = CPT * 16;

  logic       clk = 1'b0;
  logic       reset, rx, parity_en, parity_odd, fifo_full, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, busy, framing_err, parity_err, overrun_err;

  int         total = 0;
  int         bad = 0;
  int         vcount = 0;
  int         run = 0;
  int         max_run = 0;
  logic [7:0] vdata [0:63];

  uart_rx_deserializer #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .parity_en(parity_en), .parity_odd(parity_odd),
    .fifo_full(fifo_full), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .framing_err(framing_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Record every strobe and the longest run of consecutive high samples.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (vcount < 64) vdata[vcount] = rx_data;
      vcount = vcount + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic pbit,
                      input logic stop, input int stop_len);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (pen) drive_bit(pbit, BIT);
    drive_bit(stop, stop_len);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int         base;
    logic       found;
    logic [7:0] b99;
    b99        = 8'h99;
    reset      = 1'b1;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    fifo_full  = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({framing_err, parity_err, overrun_err}), 32'd0);

    // 8N1 back-to-back frames
    base = vcount;
    send(8'h55, 1'b0, 1'b0, 1'b1, BIT);
    chk("busy_between", 32'(busy), 32'd0);
    send(8'hA3, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("b2b_count", 32'(vcount - base), 32'd2);
    chk("b2b_data0", 32'(vdata[base]), 32'h55);
    chk("b2b_data1", 32'(vdata[base + 1]), 32'hA3);
    chk("b2b_width", 32'(max_run), 32'd1);
    chk("b2b_flags", 32'({framing_err, parity_err, overrun_err}), 32'd0);
    chk("b2b_idle", 32'(busy), 32'd0);

    // 8E1: 0x07 has three ones, so the even-parity bit is 1
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    base = vcount;
    send(8'h07, 1'b1, 1'b1, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("par_ok_count", 32'(vcount - base), 32'd1);
    chk("par_ok_data", 32'(rx_data), 32'h07);
    chk("par_ok_flag", 32'(parity_err), 32'd0);
    send(8'h07, 1'b1, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("par_bad_count", 32'(vcount - base), 32'd1);
    chk("par_bad_flag", 32'(parity_err), 32'd1);
    chk("par_bad_data", 32'(rx_data), 32'h07);
    chk("par_bad_framing", 32'(framing_err), 32'd0);
    pulse_clr();
    chk("par_clr", 32'(parity_err), 32'd0);
    parity_en = 1'b0;

    // False start: 3-tick glitch
    base = vcount;
    drive_bit(1'b0, 3 * CPT);
    drive_bit(1'b1, 200);
    chk("glitch_count", 32'(vcount - base), 32'd0);
    chk("glitch_flags", 32'({framing_err, parity_err, overrun_err}), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);
    send(8'h3C, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("glitch_next_count", 32'(vcount - base), 32'd1);
    chk("glitch_next_data", 32'(rx_data), 32'h3C);

    // Framing error followed by a 40-bit-time break
    base = vcount;
    send(8'hFF, 1'b0, 1'b0, 1'b0, BIT);
    drive_bit(1'b0, 20 * BIT);
    chk("brk_framing", 32'(framing_err), 32'd1);
    chk("brk_parity", 32'(parity_err), 32'd0);
    chk("brk_busy", 32'(busy), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    drive_bit(1'b0, 20 * BIT);
    chk("brk_no_repeat", 32'(framing_err), 32'd0);
    chk("brk_busy_hold", 32'(busy), 32'd1);
    drive_bit(1'b1, 20);
    chk("brk_release", 32'(busy), 32'd0);
    chk("brk_count", 32'(vcount - base), 32'd0);
    chk("brk_data_kept", 32'(rx_data), 32'h3C);
    send(8'h81, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("brk_next_count", 32'(vcount - base), 32'd1);
    chk("brk_next_data", 32'(rx_data), 32'h81);

    // Overrun against a full FIFO
    fifo_full = 1'b1;
    base = vcount;
    send(8'h42, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 5);
    chk("ovr_count", 32'(vcount - base), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h42);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    pulse_clr();
    chk("ovr_clr", 32'(overrun_err), 32'd0);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 20);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rx_valid) found = 1'b1;
    end
    chk("ovr_wait_valid", 32'(found), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", 32'(overrun_err), 32'd1);
    fifo_full = 1'b0;
    drive_bit(1'b1, 40);

    // Reset at data bit 4
    base = vcount;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(b99[i], BIT);
    drive_bit(b99[4], BIT / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_data", 32'(rx_data), 32'h00);
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_flags", 32'({framing_err, parity_err, overrun_err}), 32'd0);
    drive_bit(1'b1, BIT);
    chk("mrst_count", 32'(vcount - base), 32'd0);
    send(8'h99, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b1, 20);
    chk("mrst_next_count", 32'(vcount - base), 32'd1);
    chk("mrst_next_data", 32'(rx_data), 32'h99);
    chk("final_width", 32'(max_run), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
